fwrisc_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the fwrisc core, successor to the fixed 64×32, two-read-port regfile. Width, depth and read-port count are configurable. A hardware clear sequencer zeroes every entry after reset and flags completion. An optional write-to-read bypass is available. Sits between decode (read addresses) and writeback (write port); the core stalls issue until `ready` is high.

---
 rtl/fwrisc_regfile_mp.sv | 93 +++++++++
 tb/tb_fwrisc_regfile_mp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_regfile_mp.sv
// fwrisc_regfile_mp: parametrised multi-read-port register file with a post-reset clear sweep.
// Optional feature macro FWRISC_REGFILE_BYPASS_EN forwards same-edge write data to matching reads.
module fwrisc_regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned N_READ     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_READ*ADDR_WIDTH-1:0] raddr,
    output logic [N_READ*DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         wen,
    output logic                         ready
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_next [N_READ];

    // The clear sweep owns the write port until ready; entry 0 is never written afterwards.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (!reset) begin
            if (state == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = cnt[ADDR_WIDTH-1:0];
                mem_wdata = '0;
            end else if (wen && (waddr != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            rd_next[i] = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef FWRISC_REGFILE_BYPASS_EN
            if (wen && (waddr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rd_next[i] = wdata;
            end
`endif
            if (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                rd_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= StClear;
            cnt   <= '0;
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            unique case (state)
                StClear: begin
                    cnt   <= cnt + 1'b1;
                    rdata <= '0;
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state <= StReady;
                        ready <= 1'b1;
                    end
                end
                StReady: begin
                    for (int i = 0; i < N_READ; i++) begin
                        rdata[i*DATA_WIDTH +: DATA_WIDTH] <= rd_next[i];
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// Self-checking bench for fwrisc_regfile_mp: a default 2-port instance and a 4-port 64-bit one,
// each compared every cycle against an array model, plus literal spot checks.
module tb_fwrisc_regfile_mp;
    localparam int unsigned AW_A = 6, DW_A = 32, NR_A = 2, DEP_A = 64;
    localparam int unsigned AW_B = 5, DW_B = 64, NR_B = 4, DEP_B = 32;
`ifdef FWRISC_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [NR_A*AW_A-1:0] raddr_a = '0;
    logic [NR_A*DW_A-1:0] rdata_a;
    logic [AW_A-1:0]      waddr_a = '0;
    logic [DW_A-1:0]      wdata_a = '0;
    logic                 wen_a = 1'b0;
    logic                 ready_a;

    logic [NR_B*AW_B-1:0] raddr_b = '0;
    logic [NR_B*DW_B-1:0] rdata_b;
    logic [AW_B-1:0]      waddr_b = '0;
    logic [DW_B-1:0]      wdata_b = '0;
    logic                 wen_b = 1'b0;
    logic                 ready_b;

    always #5 clock = ~clock;

    fwrisc_regfile_mp u_dut_a (
        .clock(clock), .reset(reset), .raddr(raddr_a), .rdata(rdata_a),
        .waddr(waddr_a), .wdata(wdata_a), .wen(wen_a), .ready(ready_a)
    );

    fwrisc_regfile_mp #(.DATA_WIDTH(DW_B), .ADDR_WIDTH(AW_B), .N_READ(NR_B)) u_dut_b (
        .clock(clock), .reset(reset), .raddr(raddr_b), .rdata(rdata_b),
        .waddr(waddr_b), .wdata(wdata_b), .wen(wen_b), .ready(ready_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a reset wipes the array (the sweep finishes before any write can land), and the
    // port is unusable until DEPTH non-reset edges have passed.
    bit              mvalid = 1'b0;
    int              ea = 0, eb = 0;
    bit              ma_ready, mb_ready;
    logic [DW_A-1:0] ma_mem [DEP_A];
    logic [DW_B-1:0] mb_mem [DEP_B];
    logic [DW_A-1:0] ma_rd [NR_A];
    logic [DW_B-1:0] mb_rd [NR_B];

    always @(posedge clock) begin
        if (reset) begin
            mvalid   <= 1'b1;
            ea       <= 0;
            eb       <= 0;
            ma_ready <= 1'b0;
            mb_ready <= 1'b0;
            for (int k = 0; k < DEP_A; k++) ma_mem[k] <= '0;
            for (int k = 0; k < DEP_B; k++) mb_mem[k] <= '0;
            for (int p = 0; p < NR_A; p++) ma_rd[p] <= '0;
            for (int p = 0; p < NR_B; p++) mb_rd[p] <= '0;
        end else if (mvalid) begin
            if (ea < DEP_A) begin
                ea       <= ea + 1;
                ma_ready <= (ea + 1 >= DEP_A);
                for (int p = 0; p < NR_A; p++) ma_rd[p] <= '0;
            end else begin
                for (int p = 0; p < NR_A; p++) begin
                    if (raddr_a[p*AW_A +: AW_A] == 0) ma_rd[p] <= '0;
                    else if (BYPASS && wen_a && waddr_a == raddr_a[p*AW_A +: AW_A])
                        ma_rd[p] <= wdata_a;
                    else ma_rd[p] <= ma_mem[raddr_a[p*AW_A +: AW_A]];
                end
                if (wen_a && waddr_a != 0) ma_mem[waddr_a] <= wdata_a;
            end
            if (eb < DEP_B) begin
                eb       <= eb + 1;
                mb_ready <= (eb + 1 >= DEP_B);
                for (int p = 0; p < NR_B; p++) mb_rd[p] <= '0;
            end else begin
                for (int p = 0; p < NR_B; p++) begin
                    if (raddr_b[p*AW_B +: AW_B] == 0) mb_rd[p] <= '0;
                    else if (BYPASS && wen_b && waddr_b == raddr_b[p*AW_B +: AW_B])
                        mb_rd[p] <= wdata_b;
                    else mb_rd[p] <= mb_mem[raddr_b[p*AW_B +: AW_B]];
                end
                if (wen_b && waddr_b != 0) mb_mem[waddr_b] <= wdata_b;
            end
        end
    end

    always @(negedge clock) begin
        if (mvalid) begin
            check("a_ready", 64'(ready_a), 64'(ma_ready));
            check("b_ready", 64'(ready_b), 64'(mb_ready));
            for (int p = 0; p < NR_A; p++)
                check($sformatf("a_rdata%0d", p), 64'(rdata_a[p*DW_A +: DW_A]), 64'(ma_rd[p]));
            for (int p = 0; p < NR_B; p++)
                check($sformatf("b_rdata%0d", p), rdata_b[p*DW_B +: DW_B], mb_rd[p]);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held three edges, then the 64-edge sweep (32 for the small instance).
        tick(3);
        check("lit_reset_ready", 64'(ready_a), 64'd0);
        check("lit_reset_rdata", 64'(rdata_a), 64'd0);
        reset = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 31) check("lit_b_ready_31", 64'(ready_b), 64'd0);
            if (i == 32) check("lit_b_ready_32", 64'(ready_b), 64'd1);
            if (i == 63) check("lit_a_ready_63", 64'(ready_a), 64'd0);
            if (i == 64) check("lit_a_ready_64", 64'(ready_a), 64'd1);
        end
        for (int a = 0; a < 64; a++) begin
            raddr_a = {6'(63 - a), 6'(a)};
            tick();
        end
        check("lit_cleared_63", 64'(rdata_a), 64'd0);

        // Ordinary write then read; address 0 stays 0.
        wen_a = 1'b1; waddr_a = 6'd7; wdata_a = 32'h12345678; raddr_a = '0;
        tick();
        wen_a = 1'b0; raddr_a = {6'd0, 6'd7};
        tick();
        check("lit_rd7_p0", 64'(rdata_a[31:0]), 64'h12345678);
        check("lit_rd0_p1", 64'(rdata_a[63:32]), 64'd0);
        wen_a = 1'b1; waddr_a = 6'd0; wdata_a = 32'hFFFFFFFF;
        tick();
        wen_a = 1'b0; raddr_a = '0;
        tick();
        check("lit_rd0_after_wr", 64'(rdata_a), 64'd0);

        // Same-edge write and read of entry 9 holding 0x1.
        wen_a = 1'b1; waddr_a = 6'd9; wdata_a = 32'h1;
        tick();
        wdata_a = 32'hA5A5A5A5; raddr_a = {6'd9, 6'd9};
        tick();
        wen_a = 1'b0;
        check("lit_same_edge", 64'(rdata_a), BYPASS ? 64'hA5A5A5A5A5A5A5A5 : 64'h0000000100000001);
        tick();
        check("lit_next_edge", 64'(rdata_a), 64'hA5A5A5A5A5A5A5A5);

        // Reset, attempt writes during CLEAR, reset again at cnt=20.
        reset = 1'b1;
        tick();
        reset = 1'b0; wen_a = 1'b1; waddr_a = 6'd5; wdata_a = 32'hDEADBEEF;
        tick(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(63);
        check("lit_rst2_ready_63", 64'(ready_a), 64'd0);
        tick();
        check("lit_rst2_ready_64", 64'(ready_a), 64'd1);
        wen_a = 1'b0; raddr_a = {6'd5, 6'd5};
        tick();
        check("lit_rd5_zero", 64'(rdata_a), 64'd0);

        // Fill the 4-port instance with index * 0x0101...
        wen_b = 1'b1;
        for (int i = 1; i < 32; i++) begin
            waddr_b = 5'(i);
            wdata_b = 64'(i) * 64'h0101010101010101;
            tick();
        end
        wen_b = 1'b0; raddr_b = {5'd31, 5'd0, 5'd17, 5'd3};
        tick();
        check("lit_b_rd3", rdata_b[63:0], 64'h0303030303030303);
        check("lit_b_rd17", rdata_b[127:64], 64'h1111111111111111);
        check("lit_b_rd0", rdata_b[191:128], 64'd0);
        check("lit_b_rd31", rdata_b[255:192], 64'h1F1F1F1F1F1F1F1F);

        // Mixed traffic against the model.
        for (int c = 0; c < 300; c++) begin
            wen_a   = 1'($urandom_range(0, 1));
            waddr_a = 6'($urandom_range(0, 11));
            wdata_a = $urandom;
            raddr_a = {6'($urandom_range(0, 11)), 6'($urandom_range(0, 11))};
            for (int p = 0; p < NR_B; p++) raddr_b[p*AW_B +: AW_B] = 5'($urandom_range(0, 31));
            tick();
        end
        wen_a = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
